// File: rtl/run_ctrl_pkg.sv
// Shared types and helpers for the run sequencer.
package run_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, RESET, RUN, FINISH, TIMEOUT} run_state_t;

  localparam int CNT_W_DEF = 16;

  // True when the low n bits of mask are all set (n <= 64).
  function automatic logic all_ones(input logic [63:0] mask, input int n);
    logic r;
    r = 1'b1;
    for (int i = 0; i < 64; i++)
      if (i < n && !mask[i]) r = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at LIMIT instead of wrapping.
module sat_counter #(
  parameter int W     = 8,
  parameter int LIMIT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!reset)                         cnt <= '0;
    else if (clr)                       cnt <= '0;
    else if (en && cnt != W'(LIMIT))    cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/run_controller.sv
// Run sequencer: holds cores in reset, runs until all channels are done or MAX_CYCLES.
// Define RUN_CTRL_PERF_EN to add per-channel completion-cycle capture (done_cyc).
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int N_CH       = 1,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 100,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N_CH-1:0]  done_i,
  output logic             core_rst,
  output logic             busy,
  output logic             finished,
  output logic             timed_out,
  output logic [N_CH-1:0]  done_mask,
  output logic [CNT_W-1:0] cycle_cnt
`ifdef RUN_CTRL_PERF_EN
  ,output logic [N_CH*CNT_W-1:0] done_cyc
`endif
);

  localparam int RCW = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);

  run_state_t     state;
  logic [RCW-1:0] rst_cnt;
  logic           launch;
  logic           all_done;

  // start only takes effect from a resting state; there is no abort while busy
  assign launch   = start && (state == IDLE || state == FINISH || state == TIMEOUT);
  assign all_done = all_ones(64'(done_mask | done_i), N_CH);

  sat_counter #(.W(RCW), .LIMIT(RST_CYCLES)) u_rst_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (launch),
    .en    (state == RESET),
    .cnt   (rst_cnt)
  );

  sat_counter #(.W(CNT_W), .LIMIT(MAX_CYCLES)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (launch),
    .en    (state == RUN),
    .cnt   (cycle_cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      core_rst  <= 1'b1;
      busy      <= 1'b0;
      finished  <= 1'b0;
      timed_out <= 1'b0;
      done_mask <= '0;
    end else begin
      case (state)
        IDLE, FINISH, TIMEOUT: begin
          if (start) begin
            state     <= RESET;
            core_rst  <= 1'b1;
            busy      <= 1'b1;
            finished  <= 1'b0;
            timed_out <= 1'b0;
            done_mask <= '0;
          end
        end
        RESET: begin
          if (rst_cnt == RCW'(RST_CYCLES - 1)) begin
            state    <= RUN;
            core_rst <= 1'b0;
          end
        end
        RUN: begin
          done_mask <= done_mask | done_i;
          // all-done takes priority over the limit on the same cycle
          if (all_done) begin
            state    <= FINISH;
            finished <= 1'b1;
            busy     <= 1'b0;
            core_rst <= 1'b1;
          end else if (cycle_cnt == CNT_W'(MAX_CYCLES - 1)) begin
            state     <= TIMEOUT;
            timed_out <= 1'b1;
            busy      <= 1'b0;
            core_rst  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RUN_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset || launch) begin
      done_cyc <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < N_CH; i++)
        if (done_i[i] && !done_mask[i])
          done_cyc[i*CNT_W +: CNT_W] <= cycle_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
